// File: rtl/ldpc_msg_pkg.sv
// Shared LDPC message definitions: default message width, the two's-complement
// minimum (which has no sign-magnitude encoding), the sign-magnitude maximum,
// and the reference two's-complement to sign-magnitude conversion.
package ldpc_msg_pkg;

   localparam int DEF_DATA_WIDTH = 6;

   // Most negative two's-complement value: 1 followed by zeros.
   localparam logic [DEF_DATA_WIDTH-1:0] MIN_TC = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

   // Largest-magnitude negative sign-magnitude value: all ones.
   localparam logic [DEF_DATA_WIDTH-1:0] SM_MAX = {DEF_DATA_WIDTH{1'b1}};

   // Converted message plus a flag marking the one value that had to be clipped.
   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] sm;
      logic                      sat;
   } sm_msg_t;

   // Two's complement to sign-magnitude. MIN_TC clips to SM_MAX with sat set;
   // zero stays all zeros so negative zero never appears.
   function automatic sm_msg_t to_sign_mag(input logic [DEF_DATA_WIDTH-1:0] x);
      sm_msg_t                   r;
      logic [DEF_DATA_WIDTH-1:0] neg;
      neg = -x;
      if (x == MIN_TC) begin
         r.sm  = SM_MAX;
         r.sat = 1'b1;
      end else if (x[DEF_DATA_WIDTH-1]) begin
         r.sm  = {1'b1, neg[DEF_DATA_WIDTH-2:0]};
         r.sat = 1'b0;
      end else begin
         r.sm  = x;
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry is the output
// register; the skid entry catches the one beat that arrives while main is
// held. in_ready is registered and equals "skid empty", so the upstream path
// never sees a combinational dependency on out_ready.
module skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_payload,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_payload
);

   logic             main_valid;
   logic [WIDTH-1:0] main_data;
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             accept;
   logic             drain;

   assign accept      = in_valid && in_ready;
   assign drain       = main_valid && out_ready;
   assign out_valid   = main_valid;
   assign out_payload = main_data;

   // Main/skid occupancy and registered in_ready; skid refills main first so
   // beats leave in arrival order.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_ready   <= 1'b0;
      end else if (!main_valid || drain) begin
         // Main is free at this edge; skid is empty after it in every case.
         in_ready <= 1'b1;
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_payload;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         // Main is held: park the beat and stop accepting until main moves.
         skid_valid <= 1'b1;
         skid_data  <= in_payload;
         in_ready   <= 1'b0;
      end else begin
         in_ready <= !skid_valid;
      end
   end

endmodule

// File: rtl/t_to_s_stream.sv
// Streaming two's-complement to sign-magnitude converter for the
// variable-to-check message path. Beats are converted as they are accepted,
// buffered in a 2-entry skid buffer together with their saturation flag, and
// saturated acceptances are counted in a sticky-at-max counter.
module t_to_s_stream
   import ldpc_msg_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_sat,
   input  logic                     sat_clr,
   output logic [SAT_CNT_WIDTH-1:0] sat_count
);

   logic [DATA_WIDTH-1:0] conv_data;
   logic                  conv_sat;
   logic [DATA_WIDTH:0]   out_payload;
   logic                  accept;

   generate
      if (DATA_WIDTH == DEF_DATA_WIDTH) begin : g_pkg_conv
         sm_msg_t conv;
         // Default width shares the package conversion used as the reference.
         always_comb begin
            conv      = to_sign_mag(in_data);
            conv_data = conv.sm;
            conv_sat  = conv.sat;
         end
      end else begin : g_gen_conv
         localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         logic [DATA_WIDTH-1:0] neg;
         // Same rule at an arbitrary width: clip the minimum, negate other negatives.
         always_comb begin
            neg = -in_data;
            if (in_data == MIN_VAL) begin
               conv_data = {DATA_WIDTH{1'b1}};
               conv_sat  = 1'b1;
            end else if (in_data[DATA_WIDTH-1]) begin
               conv_data = {1'b1, neg[DATA_WIDTH-2:0]};
               conv_sat  = 1'b0;
            end else begin
               conv_data = in_data;
               conv_sat  = 1'b0;
            end
         end
      end
   endgenerate

   skid_buf #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_skid_buf (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  ({conv_sat, conv_data}),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload)
   );

   assign {out_sat, out_data} = out_payload;
   assign accept              = in_valid && in_ready;

   // Saturation event counter: counts at acceptance, so output backpressure
   // does not delay it; clear beats a simultaneous increment; holds at max.
   always_ff @(posedge clk) begin
      if (rst || sat_clr) begin
         sat_count <= '0;
      end else if (accept && conv_sat && (sat_count != {SAT_CNT_WIDTH{1'b1}})) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: doc/t_to_s_stream.md
# t_to_s_stream

Streaming two's-complement to sign-magnitude converter for LDPC decoder messages, the inverse of the sign-magnitude to two's-complement conversion on the check-to-variable path. It sits on the variable-node to check-node edge, so that min-sum check nodes receive sign-magnitude operands. It is fully pipelined with a valid/ready handshake and a 2-entry skid buffer. It saturates the one unrepresentable input value and counts those saturation events.

## Interface
- DATA_WIDTH, 6: message width; the MSB is the sign in both formats.
- SAT_CNT_WIDTH, 16: width of the saturation event counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat; a transfer occurs when in_valid && in_ready.
- in_data  in  DATA_WIDTH  two's-complement message.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  DATA_WIDTH  sign-magnitude message.
- out_sat  out  1  the current out_data beat was saturated; travels with the beat.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  SAT_CNT_WIDTH  number of saturated beats accepted since reset or clear; sticks at its maximum value.

## Operation
- Conversion is applied at input acceptance, and the converted value is stored.
- Non-negative input x (MSB 0): the output is x unchanged.
- Negative input x other than the minimum: the output is {1, -x[DATA_WIDTH-2:0]}.
- Minimum value 1 followed by zeros (-32 at width 6) has no sign-magnitude encoding. It maps to all ones (-31) with out_sat=1.
- Zero maps to all zeros. Negative zero is never produced.
- The skid buffer has two entries: an output register (main) and a skid register.
- Accepted beat with main empty, or main draining this cycle: the beat goes to main.
- Accepted beat while main is held (out_valid && !out_ready): the beat goes to skid.
- When main drains and skid is full, skid moves to main in the same edge.
- in_ready is registered and equals !skid_full. While rst is high it is forced to 0.
- Beats are delivered in order, with no loss and no duplication.
- sat_count increments by 1 on each accepted beat that is saturated, and holds at 2^SAT_CNT_WIDTH-1.
- sat_clr and a saturated acceptance in the same cycle: clear wins, and the count becomes 0.
- Reset values: out_valid=0, out_data=0, out_sat=0, sat_count=0, skid empty, in_ready=0 during reset.
- in_ready becomes 1 on the first cycle after rst deasserts.
- Reset mid-stream discards all buffered beats. No partial beat is ever presented.

## Timing
- Latency is 1 cycle: a beat accepted at edge N has out_valid high after edge N.
- Throughput is 1 beat/cycle sustained while out_ready=1.
- Under backpressure with a continuous input, a second beat is accepted into skid. in_ready falls after that edge, so at most 2 beats are buffered.
- On out_ready reassertion: main drains, skid moves to main, and in_ready rises the following cycle.
- out_data, out_valid and out_sat stay stable while out_valid && !out_ready.
- sat_count reflects an accepted saturated beat one cycle after acceptance, independent of output backpressure.

## Structure
- Shared package ldpc_msg_pkg holds:
  - the default DATA_WIDTH;
  - localparams for MIN_TC (minimum two's-complement value) and SM_MAX (all ones);
  - a function to_sign_mag(x) returning {sm, sat}, also used by the bench as the reference model.
- The natural sub-module is skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width. Its payload here is {out_sat, out_data}.
- The top level holds the conversion logic and the saturation counter.

## Test plan
- Reset release with out_ready=1, feeding 000101 then 111011 -> out_data 000101 then 100101, out_sat=0, one cycle latency each, sat_count=0.
- Feed 100000 -> out_data 111111, out_sat=1, sat_count=1 on the next cycle. A following 000000 -> 000000, out_sat=0.
- Exhaustive sweep of all 64 inputs back-to-back -> every output matches to_sign_mag. Converting back through the sign-magnitude to two's-complement conversion returns the input for all but 100000, which returns 100001.
- Hold out_ready=0 for 3 cycles while in_valid=1 with 1,2,3,4 -> beats 1,2 accepted, in_ready=0 from the cycle after the 2nd accept, out_data stable at 1. On release the output is 1,2,3,4 in order with no gaps.
- SAT_CNT_WIDTH=2, feed 5 beats of 100000 -> sat_count 1,2,3,3,3. Asserting sat_clr together with a 6th saturated beat -> sat_count=0.
- Assert rst with both buffer entries full -> out_valid=0, sat_count=0 and in_ready=0 the next cycle; in_ready=1 one cycle after rst drops; no stale beat is emitted.
